// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types for the fetch/data memory port arbiter.
// Revision : 1.0
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

    typedef enum logic [0:0] {
        PRI_DATA  = 1'b0,
        PRI_FETCH = 1'b1
    } arb_state_e;

    function automatic logic is_read_owner(input owner_e own);
        return own != OWN_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_resp_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mem_resp_pipe
// Brief    : In-flight owner pipe, read-response routing and sticky error check.
// Revision : 1.0
// ============================================================================
module mem_resp_pipe
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int DWIDTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        i_push_owner,
    input  logic [DWIDTH-1:0] i_mem_data,
    input  logic              i_mem_data_vld,
    output logic              o_if_rvalid,
    output logic [DWIDTH-1:0] o_if_rdata,
    output logic              o_d_rvalid,
    output logic [DWIDTH-1:0] o_d_rdata,
    output logic              o_err
);

    // Stage k holds the owner of the accept made k+1 cycles ago; the last
    // stage lines up with the cycle the memory returns its data.
    owner_e              r_own [MEM_LAT+1];
    owner_e              w_head;
    logic                w_if_hit;
    logic                w_d_hit;
    logic                w_mismatch;
    logic                r_if_rvalid;
    logic                r_d_rvalid;
    logic [DWIDTH-1:0]   r_if_rdata;
    logic [DWIDTH-1:0]   r_d_rdata;
    logic                r_err;

    assign w_head     = r_own[MEM_LAT];
    assign w_if_hit   = i_mem_data_vld && (w_head == OWN_FETCH);
    assign w_d_hit    = i_mem_data_vld && (w_head == OWN_DATA);
    assign w_mismatch = i_mem_data_vld ? !is_read_owner(w_head) : is_read_owner(w_head);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= MEM_LAT; i++) begin
                r_own[i] <= OWN_NONE;
            end
        end else begin
            r_own[0] <= owner_e'(i_push_owner);
            for (int i = 1; i <= MEM_LAT; i++) begin
                r_own[i] <= r_own[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_if_rvalid <= w_if_hit;
            r_d_rvalid  <= w_d_hit;
            if (w_if_hit) begin
                r_if_rdata <= i_mem_data;
            end
            if (w_d_hit) begin
                r_d_rdata <= i_mem_data;
            end
            if (w_mismatch) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_if_rvalid = r_if_rvalid;
    assign o_if_rdata  = r_if_rdata;
    assign o_d_rvalid  = r_d_rvalid;
    assign o_d_rdata   = r_d_rdata;
    assign o_err       = r_err;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Fetch/data arbiter for the shared memory port with starvation guard.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH       = 32,
    parameter int DWIDTH       = 32,
    parameter int MEM_LAT      = 1,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [AWIDTH-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DWIDTH-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [AWIDTH-1:0] d_addr_i,
    input  logic [DWIDTH-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DWIDTH-1:0] d_rdata_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i,
    input  logic              mem_data_vld_i,
    output logic              err_o
);

    localparam int                 c_CNT_W   = $clog2(MAX_DATA_RUN + 1);
    localparam logic [c_CNT_W-1:0] c_RUN_MAX = c_CNT_W'(MAX_DATA_RUN);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [c_CNT_W-1:0]  r_run_cnt;
    logic [c_CNT_W-1:0]  w_run_cnt_nxt;
    logic                w_if_gnt;
    logic                w_d_gnt;
    logic [1:0]          w_push_owner;
    logic [AWIDTH-1:0]   r_mem_addr;
    logic [DWIDTH-1:0]   r_mem_data;
    logic                r_mem_rd;
    logic                r_mem_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= PRI_DATA;
            r_run_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_run_cnt <= w_run_cnt_nxt;
        end
    end

    always_comb begin
        w_if_gnt      = 1'b0;
        w_d_gnt       = 1'b0;
        w_state_nxt   = r_state;
        w_run_cnt_nxt = r_run_cnt;

        if (!rst) begin
            if (r_state == PRI_FETCH) begin
                w_if_gnt = if_req_i;
                w_d_gnt  = d_req_i & ~if_req_i;
            end else begin
                w_d_gnt  = d_req_i;
                w_if_gnt = if_req_i & ~d_req_i;
            end
        end

        // The run only counts data grants that made a waiting fetch wait longer.
        if (w_if_gnt || !if_req_i) begin
            w_run_cnt_nxt = '0;
        end else if (w_d_gnt) begin
            w_run_cnt_nxt = r_run_cnt + c_CNT_W'(1);
        end

        case (r_state)
            PRI_DATA: begin
                if (w_run_cnt_nxt == c_RUN_MAX) begin
                    w_state_nxt = PRI_FETCH;
                end
            end
            PRI_FETCH: begin
                if (w_if_gnt) begin
                    w_state_nxt = PRI_DATA;
                end
            end
            default: w_state_nxt = PRI_DATA;
        endcase
    end

    always_comb begin
        w_push_owner = OWN_NONE;
        if (w_if_gnt) begin
            w_push_owner = OWN_FETCH;
        end else if (w_d_gnt && !d_we_i) begin
            w_push_owner = OWN_DATA;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
        end else begin
            r_mem_rd <= w_if_gnt | (w_d_gnt & ~d_we_i);
            r_mem_wr <= w_d_gnt & d_we_i;
            if (w_if_gnt) begin
                r_mem_addr <= if_addr_i;
            end else if (w_d_gnt) begin
                r_mem_addr <= d_addr_i;
            end
            if (w_d_gnt && d_we_i) begin
                r_mem_data <= d_wdata_i;
            end
        end
    end

    mem_resp_pipe #(
        .MEM_LAT (MEM_LAT),
        .DWIDTH  (DWIDTH)
    ) u_resp_pipe (
        .clk            (clk),
        .rst            (rst),
        .i_push_owner   (w_push_owner),
        .i_mem_data     (mem_data_i),
        .i_mem_data_vld (mem_data_vld_i),
        .o_if_rvalid    (if_rvalid_o),
        .o_if_rdata     (if_rdata_o),
        .o_d_rvalid     (d_rvalid_o),
        .o_d_rdata      (d_rdata_o),
        .o_err          (err_o)
    );

    assign if_gnt_o       = w_if_gnt;
    assign d_gnt_o        = w_d_gnt;
    assign mem_addr_o     = r_mem_addr;
    assign mem_data_o     = r_mem_data;
    assign mem_read_en_o  = r_mem_rd;
    assign mem_write_en_o = r_mem_wr;

endmodule
`default_nettype wire
